mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
MEM-stage load/store unit. It consumes the memory-control and data fields that the EX/MEM pipeline register presents, and runs one data-memory bus transaction per load or store. It formats store byte-lanes and load results, and drives mem_stall back to the pipeline registers so the MEM-stage instruction is held until the access completes. It is the consumer side of the EX/MEM memory interface.

Parameters:
XLEN, 32, datapath and address width (only 32 supported).
TIMEOUT, 255, cycles waited for dmem_ready before faulting; 0 disables the timeout.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
MEM_memory_read  input  1  load in MEM stage
MEM_memory_write  input  1  store in MEM stage
MEM_funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
MEM_alu_result  input  XLEN  effective byte address
MEM_read_data2  input  XLEN  store source data
ext_stall  input  1  stall from other pipeline sources
dmem_req  output  1  bus request, held until accepted
dmem_we  output  1  1 = store
dmem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  XLEN  lane-replicated store data
dmem_wstrb  output  4  byte enables (0000 on loads)
dmem_ready  input  1  transaction complete; rdata valid same cycle
dmem_rdata  input  XLEN  raw word read data
load_data  output  XLEN  formatted, extended load result
mem_stall  output  1  hold EX/MEM and earlier stages
misaligned  output  1  combinational misaligned-access flag
access_fault  output  1  timeout fault, valid in DONE

Behaviour:
- Reset (async, immediate): state IDLE. dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, load_data=0, access_fault=0, timeout counter=0. A reset mid-transaction drops dmem_req at once; the memory side must tolerate the abandoned request.
- access = MEM_memory_read | MEM_memory_write. When both are set, the access is treated as a store.
- misaligned:
  - H/HU with addr[0]=1, or W with addr[1:0]!=00, while access=1 -> misaligned=1.
  - No request is issued and mem_stall=0. Trap handling is done elsewhere.
- funct3 011/110/111 with access=1: no request, no stall, load_data unchanged.
- States IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: on a legal aligned access, register dmem_addr/we/wdata/wstrb and go to BUSY. mem_stall=1 combinationally in this cycle. Otherwise mem_stall=0.
  - BUSY: dmem_req=1 and bus outputs stay stable; mem_stall=1; the counter increments each cycle.
    - dmem_ready=1 -> capture and format dmem_rdata into load_data (loads only), clear counter, go to DONE.
    - TIMEOUT!=0 and counter reaches TIMEOUT-1 without ready -> drop req, access_fault=1, go to DONE.
  - DONE: dmem_req=0, mem_stall=0 so the pipeline advances at the end of this cycle.
    - Stay in DONE while ext_stall=1, so the same held instruction is not reissued.
    - Return to IDLE on the first cycle with ext_stall=0.
    - access_fault clears on leaving DONE.
- Minimum latency: 3 cycles per access (IDLE, BUSY with ready, DONE). Each extra wait state adds one cycle.
- Store formatting by addr[1:0]:
  - SB: wdata = byte replicated x4; wstrb = 0001 << addr[1:0].
  - SH: wdata = half replicated x2; wstrb = 0011 or 1100.
  - SW: wdata = data; wstrb = 1111.
- Load formatting: select the byte/half lane by addr[1:0].
  - B/H: sign-extend to XLEN.
  - BU/HU: zero-extend.
  - W: pass through.
- load_data holds its value until the next completed load. Stores and faults never change it.
- dmem_ready outside BUSY is ignored.

Test Plan:
- LW addr 0x100, ready after 2 wait cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, wstrb 0000; mem_stall high for 4 cycles; load_data 0xDEADBEEF in DONE.
- LB addr 0x203 with rdata 0x80FF1234 -> load_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at addr 0x202 -> 0xFFFF80FF.
- SB addr 0x11, data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 0010. SH addr 0x12, data 0x1234 -> wdata 0x12341234, wstrb 1100. load_data unchanged.
- LW addr 0x102 -> misaligned=1, dmem_req never asserts, mem_stall=0.
- Load with ext_stall=1 for 3 cycles after ready -> FSM stays in DONE, exactly one dmem_req assertion.
- TIMEOUT=4, ready never asserted -> req for 4 cycles, then access_fault=1 in DONE. Also: reset asserted during BUSY -> dmem_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-memory bus transaction per load/store,
// store lane formatting, load extraction/extension and pipeline stall control.
module mem_stage_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MEM_memory_read,
  input  logic            MEM_memory_write,
  input  logic [2:0]      MEM_funct3,
  input  logic [XLEN-1:0] MEM_alu_result,
  input  logic [XLEN-1:0] MEM_read_data2,
  input  logic            ext_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic            mem_stall,
  output logic            misaligned,
  output logic            access_fault
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] load_q, load_d;
  logic            fault_q, fault_d;

  logic            access, f3_ok, is_half, is_word, legal;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] ld_fmt;

  assign access  = MEM_memory_read | MEM_memory_write;
  assign f3_ok   = (MEM_funct3 == 3'b000) || (MEM_funct3 == 3'b001) || (MEM_funct3 == 3'b010) ||
                   (MEM_funct3 == 3'b100) || (MEM_funct3 == 3'b101);
  assign is_half = (MEM_funct3[1:0] == 2'b01);
  assign is_word = (MEM_funct3 == 3'b010);

  assign misaligned = access & ((is_half & MEM_alu_result[0]) |
                                (is_word & (|MEM_alu_result[1:0])));
  assign legal      = access & f3_ok & ~misaligned;

  always_comb begin
    st_wdata = MEM_read_data2;
    st_wstrb = 4'b1111;
    case (MEM_funct3[1:0])
      2'b00: begin
        st_wdata = {4{MEM_read_data2[7:0]}};
        st_wstrb = 4'b0001 << MEM_alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{MEM_read_data2[15:0]}};
        st_wstrb = MEM_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = dmem_rdata[7:0];
    case (off_q)
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      2'd3:    lane_b = dmem_rdata[31:24];
      default: ;
    endcase
    lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, lane_b};
      3'b001:  ld_fmt = {{(XLEN-16){lane_h[15]}}, lane_h};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, lane_h};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f3_d      = f3_q;
    off_d     = off_q;
    load_d    = load_q;
    fault_d   = fault_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (legal) begin
          mem_stall = 1'b1;
          addr_d    = {MEM_alu_result[XLEN-1:2], 2'b00};
          we_d      = MEM_memory_write;
          wdata_d   = st_wdata;
          wstrb_d   = MEM_memory_write ? st_wstrb : '0;
          f3_d      = MEM_funct3;
          off_d     = MEM_alu_result[1:0];
          cnt_d     = '0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (dmem_ready) begin
          if (!we_q) load_d = ld_fmt;
          cnt_d   = '0;
          fault_d = 1'b0;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Holding here while stalled keeps the same instruction from reissuing.
        if (!ext_stall) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      load_q  <= load_d;
      fault_q <= fault_d;
    end
  end

  assign dmem_req     = (state_q == S_BUSY);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign load_data    = load_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a per-cycle compare against an arithmetic
// model of the access rules, plus literal checks of the documented examples.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, ext_stall, dmem_ready;
  logic [2:0]  f3;
  logic [31:0] alu, data2, rdata;
  logic        dmem_req, dmem_we, mem_stall, misaligned, access_fault;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_wstrb;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MEM_memory_read(rd), .MEM_memory_write(wr), .MEM_funct3(f3),
    .MEM_alu_result(alu), .MEM_read_data2(data2), .ext_stall(ext_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(rdata), .load_data(load_data), .mem_stall(mem_stall),
    .misaligned(misaligned), .access_fault(access_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic        chk_en = 1'b0;
  logic        exp_req = 1'b0, exp_stall = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_load = '0;
  int          req_rises = 0;
  logic        req_prev = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_size(input logic [2:0] fn);
    if (fn == 3'd0 || fn == 3'd4) return 1;
    if (fn == 3'd1 || fn == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_misaligned(input logic r, input logic w, input logic [2:0] fn,
                                        input logic [31:0] a);
    if (!(r || w)) return 1'b0;
    if (fn == 3'd2) return (a % 4) != 0;
    if (fn == 3'd1 || fn == 3'd5) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] d);
    case (m_size(fn))
      1: return (d & 32'hFF) * 32'h0101_0101;
      2: return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic w, input logic [2:0] fn, input logic [31:0] a);
    int unsigned mask;
    if (!w) return 4'd0;
    mask = ((1 << m_size(fn)) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [31:0] a,
                                         input logic [31:0] word);
    longint v;
    int     bits;
    bits = 8 * m_size(fn);
    if (bits == 32) return word;
    v = longint'({32'd0, word} >> (8 * (a % 4)));
    v = v & ((longint'(1) << bits) - 1);
    if (fn < 3'd4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (dmem_req && !req_prev) req_rises++;
    req_prev = dmem_req;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 32'(dmem_req), 32'(exp_req));
      check("stall", 32'(mem_stall), 32'(exp_stall));
      check("fault", 32'(access_fault), 32'(exp_fault));
      check("load_data", load_data, exp_load);
      check("misaligned", 32'(misaligned), 32'(m_misaligned(rd, wr, f3, alu)));
      if (exp_req) begin
        check("addr", dmem_addr, alu - (alu % 4));
        check("we", 32'(dmem_we), 32'(wr));
        check("wstrb", 32'(dmem_wstrb), 32'(m_wstrb(wr, f3, alu)));
        if (wr) check("wdata", dmem_wdata, m_wdata(f3, data2));
      end
    end
  end

  task automatic go_idle();
    @(posedge clk); #1;
    rd = 0; wr = 0; f3 = 3'd0; alu = 32'h0; data2 = 32'h0;
    ext_stall = 0; dmem_ready = 1'b1; rdata = 32'h5555_AAAA;   // stray ready: must be ignored
    exp_req = 0; exp_stall = 0; exp_fault = 0;
  endtask

  // IDLE cycle, waits+1 BUSY cycles (ready on the last), then ext+1 DONE cycles.
  task automatic access(input logic r, input logic w, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] word, input int waits, input int ext);
    @(posedge clk); #1;
    rd = r; wr = w; f3 = fn; alu = a; data2 = d; rdata = word;
    dmem_ready = 0; ext_stall = 0;
    exp_req = 0; exp_stall = 1;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      exp_req = 1; exp_stall = 1;
      dmem_ready = (i == waits);
      if (i == 0) begin
        cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_wstrb = dmem_wstrb;
      end
    end
    @(posedge clk); #1;
    dmem_ready = 0; exp_req = 0; exp_stall = 0;
    if (r && !w) exp_load = m_load(fn, a, word);
    ext_stall = (ext > 0);
    for (int i = 0; i < ext; i++) begin
      @(posedge clk); #1;
      ext_stall = (i < ext - 1);
    end
    go_idle();
  endtask

  task automatic no_access(input logic r, input logic w, input logic [2:0] fn, input logic [31:0] a);
    int rises0;
    rises0 = req_rises;
    @(posedge clk); #1;
    rd = r; wr = w; f3 = fn; alu = a; data2 = 32'hFFFF_FFFF; dmem_ready = 0;
    exp_req = 0; exp_stall = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("no_req_issued", 32'(req_rises), 32'(rises0));
    go_idle();
  endtask

  initial begin
    int rises0;
    reset = 1; rd = 0; wr = 0; f3 = 0; alu = 0; data2 = 0; ext_stall = 0;
    dmem_ready = 0; rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_fault", 32'(access_fault), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    @(negedge clk); reset = 0;
    chk_en = 1;

    access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0);
    check("lw_addr_lit", cap_addr, 32'h100);
    check("lw_wstrb_lit", 32'(cap_wstrb), 32'h0);
    check("lw_data_lit", load_data, 32'hDEAD_BEEF);

    access(1, 0, 3'd0, 32'h203, 32'h0, 32'h80FF_1234, 0, 0);
    check("lb_lit", load_data, 32'hFFFF_FF80);
    access(1, 0, 3'd4, 32'h203, 32'h0, 32'h80FF_1234, 1, 0);
    check("lbu_lit", load_data, 32'h0000_0080);
    access(1, 0, 3'd5, 32'h200, 32'h0, 32'h80FF_9234, 0, 0);
    check("lhu_lit", load_data, 32'h0000_9234);
    access(1, 0, 3'd1, 32'h202, 32'h0, 32'h80FF_1234, 0, 0);
    check("lh_lit", load_data, 32'hFFFF_80FF);

    access(0, 1, 3'd0, 32'h11, 32'h0000_00A5, 32'h0, 0, 0);
    check("sb_wdata_lit", cap_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb_lit", 32'(cap_wstrb), 32'b0010);
    access(0, 1, 3'd1, 32'h12, 32'h0000_1234, 32'h0, 1, 0);
    check("sh_wdata_lit", cap_wdata, 32'h1234_1234);
    check("sh_wstrb_lit", 32'(cap_wstrb), 32'b1100);
    check("store_keeps_load", load_data, 32'hFFFF_80FF);
    access(0, 1, 3'd2, 32'h20, 32'hCAFE_F00D, 32'h0, 2, 1);
    access(1, 1, 3'd0, 32'h22, 32'h0000_0077, 32'h1111_1111, 0, 0);
    check("rw_is_store", 32'(cap_wstrb), 32'b0100);

    no_access(1, 0, 3'd2, 32'h102);
    no_access(0, 1, 3'd1, 32'h101);
    no_access(1, 0, 3'd3, 32'h100);
    no_access(1, 0, 3'd7, 32'h104);

    rises0 = req_rises;
    access(1, 0, 3'd2, 32'h40, 32'h0, 32'h1357_9BDF, 0, 3);
    check("ext_one_req", 32'(req_rises - rises0), 32'd1);

    // Timeout: ready withheld, request visible for exactly four BUSY cycles.
    rises0 = req_rises;
    @(posedge clk); #1;
    rd = 1; wr = 0; f3 = 3'd2; alu = 32'h300; dmem_ready = 0;
    exp_req = 0; exp_stall = 1;
    repeat (4) begin @(posedge clk); #1; exp_req = 1; exp_stall = 1; end
    @(posedge clk); #1;
    exp_req = 0; exp_stall = 0; exp_fault = 1;
    go_idle();
    @(posedge clk); #1;
    check("to_one_req", 32'(req_rises - rises0), 32'd1);
    check("to_keeps_load", load_data, 32'h1357_9BDF);

    // Reset in the middle of a bus transaction.
    @(posedge clk); #1;
    rd = 1; wr = 0; f3 = 3'd2; alu = 32'h500; dmem_ready = 0;
    exp_req = 0; exp_stall = 1;
    @(posedge clk); #1;
    exp_req = 1; exp_stall = 1;
    @(posedge clk); #1;
    chk_en = 0;
    #2 reset = 1;
    #1;
    check("rst_busy_req", 32'(dmem_req), 32'd0);
    check("rst_busy_addr", dmem_addr, 32'd0);
    check("rst_busy_load", load_data, 32'd0);
    rd = 0;
    @(negedge clk); reset = 0;
    exp_load = 32'd0; exp_req = 0; exp_stall = 0; exp_fault = 0;
    @(posedge clk); #1;
    chk_en = 1;
    access(1, 0, 3'd0, 32'h601, 32'h0, 32'h0000_7F00, 0, 0);
    check("post_rst_lb_lit", load_data, 32'h0000_007F);

    @(posedge clk); #1;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
